bram_dma_desc: RTL



---
 rtl/bram_dma_pkg.sv | 35 +++
 rtl/bram_dma_rdpipe.sv | 37 +++
 rtl/bram_dma_desc.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bram_dma_pkg.sv
// Shared types for the descriptor-driven BRAM copy engine: FSM states and
// the descriptor record sized to the default engine configuration.
package bram_dma_pkg;

    localparam int PKG_DW      = 8;
    localparam int PKG_SRC_AW  = 14;
    localparam int PKG_DST_AW  = 17;
    localparam int PKG_NUM_DST = 2;
    localparam int PKG_LEN_W   = 10;

    // A single-channel build still needs a 1-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PKG_SEL_W = sel_width(PKG_NUM_DST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [PKG_SRC_AW-1:0] src_base;
        logic [PKG_DST_AW-1:0] dst_base;
        logic [PKG_LEN_W-1:0]  burst_len;
        logic [PKG_LEN_W-1:0]  block_cnt;
        logic [PKG_SRC_AW-1:0] src_stride;
        logic [PKG_DST_AW-1:0] dst_stride;
        logic [PKG_SEL_W-1:0]  dst_sel;
    } desc_t;

endpackage

// File: rtl/bram_dma_rdpipe.sv
// Delay line carrying {valid, destination address} alongside the source BRAM
// read latency; the tail lines up with the returning read data.
module bram_dma_rdpipe #(
    parameter int RD_LAT = 1,
    parameter int AW     = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [AW-1:0] addr_i,
    output logic          tail_vld_o,
    output logic [AW-1:0] tail_addr_o,
    output logic          empty_o
);

    logic [RD_LAT-1:0]         vld_q;
    logic [RD_LAT-1:0][AW-1:0] addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            addr_q <= '0;
        end else begin
            vld_q[0]  <= push_i;
            addr_q[0] <= addr_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign tail_vld_o  = vld_q[RD_LAT-1];
    assign tail_addr_o = addr_q[RD_LAT-1];
    assign empty_o     = ~|vld_q;

endmodule

// File: rtl/bram_dma_desc.sv
// Descriptor-driven BRAM-to-BRAM copy engine: strided block reads from one
// source port, writes to one of NUM_DST destination ports.
// Optional constant-fill transfers are enabled by defining BRAM_DMA_FILL_EN.
module bram_dma_desc
    import bram_dma_pkg::*;
#(
    parameter int DW      = 8,
    parameter int SRC_AW  = 14,
    parameter int DST_AW  = 17,
    parameter int NUM_DST = 2,
    parameter int LEN_W   = 10,
    parameter int RD_LAT  = 1
`ifdef BRAM_DMA_FILL_EN
    ,
    parameter logic [DW-1:0] FILL_VAL = '0
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    input  logic [SRC_AW-1:0]             desc_src_base,
    input  logic [DST_AW-1:0]             desc_dst_base,
    input  logic [LEN_W-1:0]              desc_burst_len,
    input  logic [LEN_W-1:0]              desc_block_cnt,
    input  logic [SRC_AW-1:0]             desc_src_stride,
    input  logic [DST_AW-1:0]             desc_dst_stride,
    input  logic [sel_width(NUM_DST)-1:0] desc_dst_sel,
`ifdef BRAM_DMA_FILL_EN
    input  logic                          desc_fill,
`endif
    output logic                          src_rden,
    output logic [SRC_AW-1:0]             src_rdptr,
    input  logic [DW-1:0]                 src_rdata,
    output logic [NUM_DST-1:0]            dst_wren,
    output logic [DST_AW-1:0]             dst_addr,
    output logic [DW-1:0]                 dst_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          sel_err
);

    localparam int             SEL_W     = sel_width(NUM_DST);
    localparam logic [SEL_W:0] NUM_DST_L = (SEL_W+1)'(NUM_DST);

    state_t              state_q, state_d;
    logic [SRC_AW-1:0]   src_ptr_q, src_blk_q, src_stride_q;
    logic [DST_AW-1:0]   dst_ptr_q, dst_blk_q, dst_stride_q;
    logic [LEN_W-1:0]    beat_q, blk_q, burst_q, blocks_q;
    logic [SEL_W-1:0]    sel_q;
    logic                sel_ok_q, sel_err_q, fill_q;
    logic [DW-1:0]       fill_data;
    logic                accept, last_beat, last_blk, sel_bad;
    logic                pipe_vld, pipe_empty;
    logic [DST_AW-1:0]   pipe_addr;

    assign accept    = desc_valid && desc_ready;
    assign last_beat = (beat_q == burst_q - LEN_W'(1));
    assign last_blk  = (blk_q == blocks_q - LEN_W'(1));
    assign sel_bad   = ({1'b0, desc_dst_sel} >= NUM_DST_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        desc_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                desc_ready = 1'b1;
                busy       = 1'b0;
                if (desc_valid) begin
                    if (desc_burst_len == '0 || desc_block_cnt == '0) state_d = S_DONE;
                    else                                              state_d = S_RUN;
                end
            end
            S_RUN:   if (last_beat && last_blk) state_d = S_DRAIN;
            S_DRAIN: if (pipe_empty) state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Running block bases replace blk*stride; pointers restart from the
    // next block base at each block boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr_q    <= '0;
            src_blk_q    <= '0;
            src_stride_q <= '0;
            dst_ptr_q    <= '0;
            dst_blk_q    <= '0;
            dst_stride_q <= '0;
            beat_q       <= '0;
            blk_q        <= '0;
            burst_q      <= '0;
            blocks_q     <= '0;
            sel_q        <= '0;
            sel_ok_q     <= 1'b0;
            sel_err_q    <= 1'b0;
        end else if (accept) begin
            src_ptr_q    <= desc_src_base;
            src_blk_q    <= desc_src_base;
            src_stride_q <= desc_src_stride;
            dst_ptr_q    <= desc_dst_base;
            dst_blk_q    <= desc_dst_base;
            dst_stride_q <= desc_dst_stride;
            beat_q       <= '0;
            blk_q        <= '0;
            burst_q      <= desc_burst_len;
            blocks_q     <= desc_block_cnt;
            sel_q        <= desc_dst_sel;
            sel_ok_q     <= !sel_bad;
            if (sel_bad) sel_err_q <= 1'b1;
        end else if (state_q == S_RUN) begin
            if (last_beat) begin
                beat_q    <= '0;
                blk_q     <= blk_q + LEN_W'(1);
                src_blk_q <= src_blk_q + src_stride_q;
                src_ptr_q <= src_blk_q + src_stride_q;
                dst_blk_q <= dst_blk_q + dst_stride_q;
                dst_ptr_q <= dst_blk_q + dst_stride_q;
            end else begin
                beat_q    <= beat_q + LEN_W'(1);
                src_ptr_q <= src_ptr_q + SRC_AW'(1);
                dst_ptr_q <= dst_ptr_q + DST_AW'(1);
            end
        end
    end

`ifdef BRAM_DMA_FILL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      fill_q <= 1'b0;
        else if (accept) fill_q <= desc_fill;
    end
    assign fill_data = FILL_VAL;
`else
    assign fill_q    = 1'b0;
    assign fill_data = '0;
`endif

    bram_dma_rdpipe #(
        .RD_LAT (RD_LAT),
        .AW     (DST_AW)
    ) u_rdpipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (state_q == S_RUN),
        .addr_i      (dst_ptr_q),
        .tail_vld_o  (pipe_vld),
        .tail_addr_o (pipe_addr),
        .empty_o     (pipe_empty)
    );

    assign src_rden  = (state_q == S_RUN) && !fill_q;
    assign src_rdptr = src_ptr_q;
    assign sel_err   = sel_err_q;

    // Bad-channel transfers still walk the pipeline so timing is unchanged.
    always_comb begin
        dst_wren  = '0;
        dst_addr  = '0;
        dst_wdata = '0;
        if (pipe_vld) begin
            if (sel_ok_q) dst_wren = NUM_DST'(1) << sel_q;
            dst_addr  = pipe_addr;
            dst_wdata = fill_q ? fill_data : src_rdata;
        end
    end

endmodule
